// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: FSM states and shift direction.
package shreg_pkg;
  typedef enum logic {IDLE, SHIFT} shreg_state_e;
  typedef enum logic {DIR_LEFT, DIR_RIGHT} shreg_dir_e;
endpackage

// File: rtl/shreg_step_logic.sv
// One-bit shift next-value function, shared by the single-step and multi-cycle paths.
// Rotate support is compiled in only when SHREG_ROTATE_EN is defined.
module shreg_step_logic
  import shreg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  shreg_dir_e       dir,
  input  logic             arith,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (dir == DIR_LEFT)
      nxt = {cur[WIDTH-2:0], sin_l};
    else if (arith)
      nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
    else
      nxt = {sin_r, cur[WIDTH-1:1]};
`ifdef SHREG_ROTATE_EN
    // rotate overrides both arithmetic mode and serial-in
    if (rot)
      nxt = (dir == DIR_LEFT) ? {cur[WIDTH-2:0], cur[WIDTH-1]} : {cur[0], cur[WIDTH-1:1]};
`endif
  end

endmodule

// File: rtl/universal_shift_register.sv
// Bidirectional shift register with parallel load, single step and shift-by-N (one bit/clock).
// Optional rotate mode and rot port enabled by defining SHREG_ROTATE_EN.
module universal_shift_register
  import shreg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             step,
  input  logic             start,
  input  logic             dir,
  input  logic             arith,
  input  logic [CNT_W-1:0] shamt,
  input  logic             sin_l,
  input  logic             sin_r,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  shreg_state_e     state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] n_clamp;
  shreg_dir_e       dir_q, dir_sel;
  logic             arith_q, arith_sel;
  logic [WIDTH-1:0] shifted;

  // shift counts beyond WIDTH saturate rather than wrap
  assign n_clamp = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;

  // mode comes from the latched copy while shifting, from live pins for a step
  assign dir_sel   = busy ? dir_q : shreg_dir_e'(dir);
  assign arith_sel = busy ? arith_q : arith;

`ifdef SHREG_ROTATE_EN
  logic rot_q, rot_sel;
  assign rot_sel = busy ? rot_q : rot;
`endif

  shreg_step_logic #(.WIDTH(WIDTH)) u_step (
    .cur   (out),
    .dir   (dir_sel),
    .arith (arith_sel),
`ifdef SHREG_ROTATE_EN
    .rot   (rot_sel),
`endif
    .sin_l (sin_l),
    .sin_r (sin_r),
    .nxt   (shifted)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start && n_clamp != '0) state_nxt = SHIFT;
        SHIFT:   if (count == CNT_W'(1))     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == SHIFT);
    sout_msb = out[WIDTH-1];
    sout_lsb = out[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out     <= '0;
      count   <= '0;
      done    <= 1'b0;
      dir_q   <= DIR_LEFT;
      arith_q <= 1'b0;
`ifdef SHREG_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (load) begin
        out   <= in;
        count <= '0;
      end else if (state == IDLE) begin
        if (start) begin
          dir_q   <= shreg_dir_e'(dir);
          arith_q <= arith;
`ifdef SHREG_ROTATE_EN
          rot_q   <= rot;
`endif
          count   <= n_clamp;
          if (n_clamp == '0) done <= 1'b1;
        end else if (step) begin
          out <= shifted;
        end
      end else begin
        out   <= shifted;
        count <= count - CNT_W'(1);
        if (count == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=16) with a cycle-level reference model.
module tb_universal_shift_register;
  localparam int W = 16;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0, reset = 1'b1;
  logic          load = 0, step = 0, start = 0, dir = 0, arith = 0, sin_l = 0, sin_r = 0, rot = 0;
  logic [W-1:0]  in = '0;
  logic [CW-1:0] shamt = '0;
  logic [W-1:0]  out;
  logic          sout_msb, sout_lsb, busy, done;

  int errors = 0, checks = 0;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .in(in), .step(step), .start(start),
    .dir(dir), .arith(arith), .shamt(shamt), .sin_l(sin_l), .sin_r(sin_r),
`ifdef SHREG_ROTATE_EN
    .rot(rot),
`endif
    .out(out), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain arithmetic on an integer-like register value
  logic [W-1:0] m_out;
  bit  m_busy, m_done, m_dir, m_ar, m_rot;
  int  m_left;

  function automatic logic [W-1:0] shf(logic [W-1:0] v, bit d, bit a, bit r, bit sl, bit sr);
    logic [W-1:0] res;
    if (r)           res = d ? ((v >> 1) | (v << (W - 1))) : ((v << 1) | (v >> (W - 1)));
    else if (!d)     res = (v << 1) | W'(sl);
    else if (a)      res = $signed(v) >>> 1;
    else             res = (v >> 1) | (W'(sr) << (W - 1));
    return res;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out = '0; m_busy = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (load) begin
        m_out = in; m_busy = 0; m_left = 0;
      end else if (!m_busy && start) begin
        m_left = (int'(shamt) > W) ? W : int'(shamt);
        m_dir = dir; m_ar = arith;
`ifdef SHREG_ROTATE_EN
        m_rot = rot;
`else
        m_rot = 0;
`endif
        if (m_left == 0) m_done = 1; else m_busy = 1;
      end else if (!m_busy && step) begin
`ifdef SHREG_ROTATE_EN
        m_out = shf(m_out, dir, arith, rot, sin_l, sin_r);
`else
        m_out = shf(m_out, dir, arith, 0, sin_l, sin_r);
`endif
      end else if (m_busy) begin
        m_out = shf(m_out, m_dir, m_ar, m_rot, sin_l, sin_r);
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_out",  out,             m_out);
      chk("cyc_busy", W'(busy),        W'(m_busy));
      chk("cyc_done", W'(done),        W'(m_done));
      chk("cyc_msb",  W'(sout_msb),    W'(m_out[W-1]));
      chk("cyc_lsb",  W'(sout_lsb),    W'(m_out[0]));
    end
  end

  task automatic cyc(); @(posedge clk); #2; endtask
  task automatic do_load(input logic [W-1:0] v);
    load = 1; in = v; cyc(); load = 0;
  endtask

  initial begin
    #1; chk("reset_out", out, 16'h0000); chk("reset_busy", W'(busy), 0); chk("reset_done", W'(done), 0);
    cyc(); cyc(); reset = 0;

    // 1: left step with serial-in
    do_load(16'h8001);
    chk("t1_msb", W'(sout_msb), 1); chk("t1_lsb", W'(sout_lsb), 1);
    dir = 0; sin_l = 1; step = 1; cyc(); step = 0; sin_l = 0;
    chk("t1_out", out, 16'h0003);

    // logical right step with sin_r, then arithmetic right step
    do_load(16'h0001); dir = 1; sin_r = 1; step = 1; cyc(); step = 0; sin_r = 0;
    chk("step_lr", out, 16'h8000);
    arith = 1; step = 1; cyc(); step = 0; arith = 0;
    chk("step_ar", out, 16'hC000);

    // 2: arithmetic right by 3
    do_load(16'h8000); dir = 1; arith = 1; shamt = 3; start = 1; cyc(); start = 0;
    dir = 0; arith = 0; shamt = 0;
    chk("t2_busy0", W'(busy), 1);
    cyc(); cyc(); chk("t2_busy2", W'(busy), 1); chk("t2_done2", W'(done), 0);
    cyc(); chk("t2_done", W'(done), 1); chk("t2_out", out, 16'hF000); chk("t2_busy3", W'(busy), 0);
    cyc(); chk("t2_done_once", W'(done), 0);

    // 3: second start mid-shift is ignored
    do_load(16'h00FF); dir = 0; sin_l = 0; shamt = 4; start = 1; cyc(); start = 0;
    cyc(); start = 1; shamt = 2; cyc(); start = 0; cyc();
    chk("t3_nodone", W'(done), 0);
    cyc(); chk("t3_done", W'(done), 1); chk("t3_out", out, 16'h0FF0);

    // 4: shamt=0 and clamping
    shamt = 0; start = 1; cyc(); start = 0;
    chk("t4_zero_done", W'(done), 1); chk("t4_zero_busy", W'(busy), 0); chk("t4_zero_out", out, 16'h0FF0);
    do_load(16'hFFFF); dir = 0; sin_l = 0; shamt = 20; start = 1; cyc(); start = 0;
    repeat (15) cyc();
    chk("t4_clamp_busy", W'(busy), 1); chk("t4_clamp_mid", out, 16'h8000);
    cyc(); chk("t4_clamp_done", W'(done), 1); chk("t4_clamp_out", out, 16'h0000);

    // 5: abort by load, then by reset
    do_load(16'hABCD); dir = 1; shamt = 5; start = 1; cyc(); start = 0; cyc();
    do_load(16'h1234);
    chk("t5_load_out", out, 16'h1234); chk("t5_load_busy", W'(busy), 0);
    repeat (6) begin cyc(); chk("t5_no_done", W'(done), 0); end
    shamt = 8; start = 1; cyc(); start = 0; cyc();
    #1 reset = 1; #1;
    chk("t5_rst_out", out, 16'h0000); chk("t5_rst_busy", W'(busy), 0);
    reset = 0;

`ifdef SHREG_ROTATE_EN
    // 6: rotate right by 4, rotate-left step
    do_load(16'h1234); rot = 1; dir = 1; shamt = 4; start = 1; cyc(); start = 0; rot = 0;
    repeat (4) cyc();
    chk("t6_rot_done", W'(done), 1); chk("t6_rot_out", out, 16'h4123);
    do_load(16'h8001); rot = 1; dir = 0; step = 1; cyc(); step = 0; rot = 0;
    chk("t6_rotl_out", out, 16'h0003);
`endif

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
